// File: rtl/truth_table_pkg.sv
// Shared types and sizing for the truth-table exhaustive sweep checker.
package truth_table_pkg;

    localparam int unsigned TT_N_IN  = 13;
    localparam int unsigned TT_N_OUT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } tt_state_e;

    // One extra bit so a full sweep of mismatches (2^n_in) fits without saturation.
    function automatic int unsigned tt_cnt_width(input int unsigned n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/tt_err_counter.sv
// Mismatch counter: increments when enabled and the two words differ.
module tt_err_counter
    import truth_table_pkg::*;
#(
    parameter int unsigned W     = TT_N_OUT,
    parameter int unsigned CNT_W = tt_cnt_width(TT_N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (a != b)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweep of the shared input vector, comparing DKNF and DDNF outputs
// against an expected-value ROM after a programmable settle time.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int unsigned N_IN       = TT_N_IN,
    parameter int unsigned N_OUT      = TT_N_OUT,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  o_x,
    output logic [N_IN-1:0]  rom_addr,
    input  logic [N_OUT-1:0] rom_data,
    input  logic [N_OUT-1:0] i_y_dknf,
    input  logic [N_OUT-1:0] i_y_ddnf,
    output logic [N_IN:0]    dknf_err_cnt,
    output logic [N_IN:0]    ddnf_err_cnt,
    output logic [N_IN-1:0]  first_fail_addr,
    output logic             first_fail_valid
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    tt_state_e  state;
    logic [3:0] settle_cnt;
    logic       clr_cnt;
    logic       chk_en;
    logic       dknf_mis;
    logic       ddnf_mis;

    assign rom_addr = o_x;
    assign clr_cnt  = (state == IDLE) && start;
    assign chk_en   = (state == CHECK);
    assign dknf_mis = (i_y_dknf != rom_data);
    assign ddnf_mis = (i_y_ddnf != rom_data);

    tt_err_counter #(.W(N_OUT), .CNT_W(tt_cnt_width(N_IN))) u_dknf_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .en  (chk_en),
        .a   (i_y_dknf),
        .b   (rom_data),
        .cnt (dknf_err_cnt)
    );

    tt_err_counter #(.W(N_OUT), .CNT_W(tt_cnt_width(N_IN))) u_ddnf_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .en  (chk_en),
        .a   (i_y_ddnf),
        .b   (rom_data),
        .cnt (ddnf_err_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            o_x              <= '0;
            settle_cnt       <= '0;
            first_fail_addr  <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state            <= SETTLE;
                        busy             <= 1'b1;
                        o_x              <= '0;
                        settle_cnt       <= SETTLE_LD;
                        first_fail_addr  <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if ((dknf_mis || ddnf_mis) && !first_fail_valid) begin
                        first_fail_addr  <= o_x;
                        first_fail_valid <= 1'b1;
                    end
                    // The all-ones vector ends the sweep; o_x stays there rather than wrapping.
                    if (o_x == '1) begin
                        state <= DONE;
                    end else begin
                        o_x        <= o_x + N_IN'(1);
                        settle_cnt <= SETTLE_LD;
                        state      <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed and randomized sweeps of truth_table_sweeper against a behavioural reference.
module tb_truth_table_sweeper;

    localparam int unsigned NI = 13;
    localparam int unsigned NO = 8;
    localparam int unsigned NV = 1 << NI;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: SETTLE_CYC=2, instance B: SETTLE_CYC=1
    logic          a_start, a_busy, a_done, a_ffv;
    logic [NI-1:0] a_x, a_raddr, a_ffa;
    logic [NO-1:0] a_rom, a_yk, a_yd;
    logic [NI:0]   a_ck, a_cd;
    logic          b_start, b_busy, b_done, b_ffv;
    logic [NI-1:0] b_x, b_raddr, b_ffa;
    logic [NO-1:0] b_rom, b_yk, b_yd;
    logic [NI:0]   b_ck, b_cd;

    bit a_ek [NV];
    bit a_ed [NV];
    bit b_ek [NV];
    bit b_ed [NV];

    logic [31:0] key1, key2;

    function automatic logic [NO-1:0] golden(input logic [NI-1:0] v);
        logic [31:0] t;
        t = {19'd0, v} * key1 + key2;
        return t[15:8] ^ t[7:0];
    endfunction

    // ROM with one cycle of read latency; implementations modelled with one cycle of settle.
    always @(posedge clk) begin
        a_rom <= golden(a_raddr);
        b_rom <= golden(b_raddr);
        a_yk  <= golden(a_x) ^ (a_ek[a_x] ? 8'hFF : 8'h00);
        a_yd  <= golden(a_x) ^ (a_ed[a_x] ? 8'hFF : 8'h00);
        b_yk  <= golden(b_x) ^ (b_ek[b_x] ? 8'hFF : 8'h00);
        b_yd  <= golden(b_x) ^ (b_ed[b_x] ? 8'hFF : 8'h00);
    end

    truth_table_sweeper #(.N_IN(NI), .N_OUT(NO), .SETTLE_CYC(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .o_x(a_x), .rom_addr(a_raddr), .rom_data(a_rom),
        .i_y_dknf(a_yk), .i_y_ddnf(a_yd),
        .dknf_err_cnt(a_ck), .ddnf_err_cnt(a_cd),
        .first_fail_addr(a_ffa), .first_fail_valid(a_ffv)
    );

    truth_table_sweeper #(.N_IN(NI), .N_OUT(NO), .SETTLE_CYC(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .o_x(b_x), .rom_addr(b_raddr), .rom_data(b_rom),
        .i_y_dknf(b_yk), .i_y_ddnf(b_yd),
        .dknf_err_cnt(b_ck), .ddnf_err_cnt(b_cd),
        .first_fail_addr(b_ffa), .first_fail_valid(b_ffv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Counts vectors below lim flagged as wrong and finds the lowest one.
    task automatic ref_model(input bit use_b, input int lim, output int ck, output int cd,
                             output int ff, output bit fv);
        ck = 0; cd = 0; ff = 0; fv = 1'b0;
        for (int v = 0; v < lim; v++) begin
            bit k, d;
            k = use_b ? b_ek[v] : a_ek[v];
            d = use_b ? b_ed[v] : a_ed[v];
            ck += int'(k);
            cd += int'(d);
            if ((k || d) && !fv) begin
                fv = 1'b1;
                ff = v;
            end
        end
    endtask

    task automatic wait_done(input bit use_b, input int budget, output int edge_at);
        edge_at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if ((use_b ? b_done : a_done) === 1'b1) begin
                edge_at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_vec(input logic [NI-1:0] v, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (a_x === v) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_errs();
        for (int v = 0; v < int'(NV); v++) begin
            a_ek[v] = 1'b0; a_ed[v] = 1'b0; b_ek[v] = 1'b0; b_ed[v] = 1'b0;
        end
    endtask

    initial begin
        int  k, e, ck, cd, ff;
        bit  fv, hit;

        key1 = $urandom | 32'd1;
        key2 = $urandom;
        clear_errs();
        a_start = 1'b0;
        b_start = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ox", a_x, 0);
        chk("rst_rom_addr", a_raddr, 0);
        chk("rst_dknf_cnt", a_ck, 0);
        chk("rst_ddnf_cnt", a_cd, 0);
        chk("rst_ffa", a_ffa, 0);
        chk("rst_ffv", a_ffv, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Sweep 1: golden on both; stray start at vector 300 on A must be ignored.
        while (cyc < 9) begin @(posedge clk); #1; end
        a_start = 1'b1; b_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0;
        k = cyc;
        chk("s1_busy_after_start", a_busy, 1);
        chk("s1_ox_after_start", a_x, 0);
        wait_vec(13'd300, 2000, hit);
        chk("s1_reach_300", hit, 1);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("s1_busy_after_stray", a_busy, 1);
        wait_done(1'b1, 20000, e);
        chk("s1b_done_edge", e, k + 1 + int'(NV) * 2);
        chk("s1b_dknf_cnt", b_ck, 0);
        chk("s1b_ddnf_cnt", b_cd, 0);
        chk("s1b_ffv", b_ffv, 0);
        wait_done(1'b0, 10000, e);
        chk("s1_done_edge", e, 10 + 24577);
        chk("s1_busy_at_done", a_busy, 0);
        chk("s1_dknf_cnt", a_ck, 0);
        chk("s1_ddnf_cnt", a_cd, 0);
        chk("s1_ffv", a_ffv, 0);
        @(posedge clk); #1;
        chk("s1_done_pulse", a_done, 0);

        // Sweep 2: DKNF wrong at 100 plus random late faults; reset at vector 4000.
        clear_errs();
        a_ek[100] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_ek[$urandom_range(NV - 1, 101)] = 1'b1;
            a_ed[$urandom_range(NV - 1, 101)] = 1'b1;
        end
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_vec(13'd4000, 15000, hit);
        chk("s2_reach_4000", hit, 1);
        ref_model(1'b0, 4000, ck, cd, ff, fv);
        chk("s2_pre_dknf_cnt", a_ck, ck);
        chk("s2_pre_ddnf_cnt", a_cd, cd);
        chk("s2_pre_ffa", a_ffa, ff);
        chk("s2_pre_ffv", a_ffv, fv);
        #2 rst = 1'b1;
        #1;
        chk("s2_rst_busy", a_busy, 0);
        chk("s2_rst_ox", a_x, 0);
        chk("s2_rst_dknf_cnt", a_ck, 0);
        chk("s2_rst_ddnf_cnt", a_cd, 0);
        chk("s2_rst_ffa", a_ffa, 0);
        chk("s2_rst_ffv", a_ffv, 0);
        @(posedge clk); #1;
        chk("s2_rst_no_done", a_done, 0);
        rst = 1'b0;

        // Sweep 3: DDNF inverted everywhere, DKNF wrong at 5/100/0x1FFF; B random faults.
        clear_errs();
        for (int v = 0; v < int'(NV); v++) begin
            a_ed[v] = 1'b1;
            b_ek[v] = ($urandom_range(63, 0) == 0);
            b_ed[v] = ($urandom_range(63, 0) == 0);
        end
        a_ek[5] = 1'b1; a_ek[100] = 1'b1; a_ek[NV - 1] = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b1; b_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0;
        k = cyc;
        wait_done(1'b1, 20000, e);
        ref_model(1'b1, int'(NV), ck, cd, ff, fv);
        chk("s3b_done_edge", e, k + 1 + int'(NV) * 2);
        chk("s3b_dknf_cnt", b_ck, ck);
        chk("s3b_ddnf_cnt", b_cd, cd);
        chk("s3b_ffa", b_ffa, ff);
        chk("s3b_ffv", b_ffv, fv);
        wait_done(1'b0, 10000, e);
        ref_model(1'b0, int'(NV), ck, cd, ff, fv);
        chk("s3_done_edge", e, k + 1 + int'(NV) * 3);
        chk("s3_dknf_cnt", a_ck, 3);
        chk("s3_ddnf_cnt", a_cd, NV);
        chk("s3_model_dknf", a_ck, ck);
        chk("s3_ffa", a_ffa, 0);
        chk("s3_ffv", a_ffv, 1);
        chk("s3_ox_final", a_x, NV - 1);
        repeat (3) @(posedge clk); #1;
        chk("s3_ox_hold", a_x, NV - 1);
        chk("s3_idle_busy", a_busy, 0);
        chk("s3_idle_done", a_done, 0);
        chk("s3_hold_ddnf_cnt", a_cd, NV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Synthesizable exhaustive-sweep checker for the 13-input, 8-output truth-table logic pair (DDNF_13_8 / DKNF_13_8).
- Upstream role: steps the shared input vector through all 8192 codes.
- Downstream role: compares both implementations' outputs against an expected-value ROM after a programmable settle time, and accumulates per-implementation mismatch counts and the first failing address.
- Replaces the simulation-only sweep with a block usable on-chip or in a self-checking FPGA build.

## Interface
Parameters:
- N_IN, 13, input vector width; sweep covers 0 .. 2^N_IN-1
- N_OUT, 8, output word width of each implementation and of the ROM
- SETTLE_CYC, 2, cycles between driving a vector and sampling; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- busy  out  1  high from the cycle after start acceptance until the DONE cycle
- done  out  1  one-cycle pulse when the sweep completes
- o_x  out  N_IN  input vector driven to both implementations
- rom_addr  out  N_IN  expected-value ROM address; always equals o_x
- rom_data  in  N_OUT  ROM word; valid 1 cycle after rom_addr changes
- i_y_dknf  in  N_OUT  DKNF implementation output
- i_y_ddnf  in  N_OUT  DDNF implementation output
- dknf_err_cnt  out  N_IN+1  DKNF mismatch count
- ddnf_err_cnt  out  N_IN+1  DDNF mismatch count
- first_fail_addr  out  N_IN  vector of the first mismatch, from either implementation
- first_fail_valid  out  1  first_fail_addr holds a valid value

## Operation
- FSM states:
  - IDLE → (start) SETTLE. On this transition: o_x=0, both counters=0, first_fail_valid=0, settle counter=SETTLE_CYC.
  - SETTLE: decrements the settle counter each cycle; enters CHECK on the cycle the counter reaches 0.
  - CHECK, single cycle:
    - If i_y_dknf≠rom_data, dknf_err_cnt+1.
    - If i_y_ddnf≠rom_data, ddnf_err_cnt+1.
    - If either mismatches and first_fail_valid=0, latch first_fail_addr=o_x and set first_fail_valid.
    - If o_x=all-ones → DONE. Otherwise o_x+1, reload the settle counter, → SETTLE.
  - DONE: done=1 for one cycle, → IDLE.
- Result outputs hold until the next accepted start or rst.
- start is ignored outside IDLE. start held high re-arms a new sweep on the cycle after DONE.
- o_x never wraps: the all-ones vector is checked exactly once, then the sweep ends.
- Counter width N_IN+1 holds the maximum count of 2^N_IN, so no saturation logic is needed.
- Both mismatches on the same vector increment both counters in the same cycle.

## Timing
- Reset values: busy=0, done=0, o_x=0, rom_addr=0, dknf_err_cnt=0, ddnf_err_cnt=0, first_fail_addr=0, first_fail_valid=0, state=IDLE.
- Start accepted at edge k: busy=1 and o_x=0 from k+1.
- Per-vector period: SETTLE_CYC+1 cycles.
- Full sweep: done asserted at edge k+1+2^N_IN·(SETTLE_CYC+1). For defaults, k+24577.
- done and busy=0 occur in the same cycle.
- The final counter values are visible in the done cycle.
- SETTLE_CYC≥1 covers the 1-cycle ROM latency. Combinational settle of the DUTs must fit within SETTLE_CYC−1 extra cycles plus one clock period.
- rst asserted mid-sweep forces all reset values immediately, asynchronously. No partial results are retained, and no done pulse is generated.

## Structure
- Package truth_table_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE)
  - constants TT_N_IN=13 and TT_N_OUT=8
  - the counter-width expression
- Sub-module tt_err_counter:
  - Inputs: clk, rst, clr, en, a, b.
  - Counts a≠b when en is high; clr zeroes the count.
  - Instantiated twice, once for DKNF and once for DDNF.
- The sweeper owns the FSM, the settle counter, o_x, and the first-fail capture.

## Test plan
- Golden ROM with both implementations correct, SETTLE_CYC=2, start at edge 10:
  - done at edge 24587
  - both counts 0
  - first_fail_valid=0
- DKNF model forced wrong only at vector 100 (0x0064):
  - dknf_err_cnt=1, ddnf_err_cnt=0
  - first_fail_addr=0x0064, first_fail_valid=1
- DDNF output inverted for all vectors, DKNF correct:
  - ddnf_err_cnt=8192, dknf_err_cnt=0
  - first_fail_addr=0
- Both implementations wrong at vectors 0x1FFF and 0x0005:
  - both counts 2
  - first_fail_addr=0x0005
  - no wrap after 0x1FFF; o_x holds 0x1FFF after done
- start pulsed at vector 300 mid-sweep: ignored; the sweep ends at the same edge as the undisturbed sweep.
- rst pulsed mid-sweep at vector 4000:
  - all outputs at reset values that same cycle
  - a following start performs a full clean sweep
- SETTLE_CYC=1: per-vector period 2 cycles; ROM-latency-aligned comparison gives zero errors with the golden ROM.
